// File: rtl/arbiter_out_rr_if.sv
// Request/grant/credit bundle between one router output port and its arbiter.
// The master side is the router fabric; the slave side is arbiter_out_rr.
interface arbiter_out_rr_if #(
    parameter int NUM_IN   = 5,
    parameter int CREDIT_W = 3
);
    logic [NUM_IN-1:0]   req;
    logic [NUM_IN-1:0]   tail;
    logic                credit_in;
    logic [NUM_IN-1:0]   grant;
    logic                owner_valid;
    logic [CREDIT_W-1:0] credit_cnt;
    logic                credit_err;

    modport master (
        output req, tail, credit_in,
        input  grant, owner_valid, credit_cnt, credit_err
    );

    modport slave (
        input  req, tail, credit_in,
        output grant, owner_valid, credit_cnt, credit_err
    );
endinterface

// File: rtl/arbiter_out_rr.sv
// Output-port arbiter: round-robin pick on release, packet-level ownership lock,
// and a local downstream credit counter with a sticky overflow flag.
module arbiter_out_rr #(
    parameter int NUM_IN     = 5,
    parameter int MAX_CREDIT = 4,
    parameter int CREDIT_W   = 3,
    parameter int LOCK_PKT   = 1
) (
    input  logic             clk,
    input  logic             reset,
    arbiter_out_rr_if.slave  bus
);
    localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam logic [CREDIT_W-1:0] CREDIT_FULL = CREDIT_W'(MAX_CREDIT);

    typedef enum logic {
        S_IDLE,
        S_OWN
    } state_t;

    typedef logic [IDX_W-1:0] idx_t;

    state_t              state_q, state_d;
    idx_t                owner_q, owner_d;
    idx_t                rr_q, rr_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                err_q, err_d;

    logic [NUM_IN-1:0]   grant_c;
    logic                granted;
    logic                owner_req;
    logic                owner_tail;
    logic                release_c;

    function automatic idx_t wrap_inc(input idx_t i);
        if (int'(i) == NUM_IN - 1)
            return '0;
        return i + 1'b1;
    endfunction

    // First requester found scanning p, p+1, ... with wrap-around.
    function automatic idx_t pick(input idx_t p, input logic [NUM_IN-1:0] r);
        idx_t idx;
        idx_t res;
        logic found;
        idx   = p;
        res   = p;
        found = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (!found && r[idx]) begin
                res   = idx;
                found = 1'b1;
            end
            idx = wrap_inc(idx);
        end
        return res;
    endfunction

    always_comb begin
        grant_c = '0;
        if (state_q == S_OWN && bus.req[owner_q] && credit_q != '0)
            grant_c[owner_q] = 1'b1;
    end

    assign granted    = |grant_c;
    assign owner_req  = bus.req[owner_q];
    assign owner_tail = bus.tail[owner_q];

    // A dropped owner request always ends ownership; with packet locking the
    // granted tail flit ends it as well.
    assign release_c = (LOCK_PKT != 0) ? (!owner_req || (granted && owner_tail))
                                       : !owner_req;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no
        // path through the case leaves a signal unassigned and infers a latch.
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        case (state_q)
            S_IDLE: begin
                if (|bus.req) begin
                    state_d = S_OWN;
                    owner_d = pick(rr_q, bus.req);
                end
            end
            S_OWN: begin
                if (release_c) begin
                    rr_d = wrap_inc(owner_q);
                    if (|bus.req)
                        owner_d = pick(wrap_inc(owner_q), bus.req);
                    else
                        state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        credit_d = credit_q;
        err_d    = err_q;
        if (granted && !bus.credit_in) begin
            credit_d = credit_q - 1'b1;
        end else if (!granted && bus.credit_in) begin
            if (credit_q == CREDIT_FULL)
                err_d = 1'b1;
            else
                credit_d = credit_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            owner_q  <= '0;
            rr_q     <= '0;
            credit_q <= CREDIT_FULL;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_q     <= rr_d;
            credit_q <= credit_d;
            err_q    <= err_d;
        end
    end

    assign bus.grant       = grant_c;
    assign bus.owner_valid = (state_q == S_OWN);
    assign bus.credit_cnt  = credit_q;
    assign bus.credit_err  = err_q;
endmodule

// File: tb/tb_arbiter_out_rr.sv
// Bench for arbiter_out_rr: one instance per LOCK_PKT setting sharing stimulus,
// each checked every cycle against a behavioural model, plus directed scenarios.
module tb_arbiter_out_rr;
    localparam int NUM_IN     = 5;
    localparam int MAX_CREDIT = 4;
    localparam int CREDIT_W   = 3;

    typedef struct {
        bit own;
        int owner;
        int rr;
        int cred;
        bit err;
    } mstate_t;

    logic              clk;
    logic              reset;
    logic [NUM_IN-1:0] req_v;
    logic [NUM_IN-1:0] tail_v;
    logic              ci_v;

    int      n_tests;
    int      n_fail;
    int      cycle;
    mstate_t m[2];

    arbiter_out_rr_if #(.NUM_IN(NUM_IN), .CREDIT_W(CREDIT_W)) if0 ();
    arbiter_out_rr_if #(.NUM_IN(NUM_IN), .CREDIT_W(CREDIT_W)) if1 ();

    assign if0.req       = req_v;
    assign if0.tail      = tail_v;
    assign if0.credit_in = ci_v;
    assign if1.req       = req_v;
    assign if1.tail      = tail_v;
    assign if1.credit_in = ci_v;

    arbiter_out_rr #(.NUM_IN(NUM_IN), .MAX_CREDIT(MAX_CREDIT), .CREDIT_W(CREDIT_W), .LOCK_PKT(0))
        dut0 (.clk(clk), .reset(reset), .bus(if0));
    arbiter_out_rr #(.NUM_IN(NUM_IN), .MAX_CREDIT(MAX_CREDIT), .CREDIT_W(CREDIT_W), .LOCK_PKT(1))
        dut1 (.clk(clk), .reset(reset), .bus(if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cycle, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int m_pick(input int p, input logic [NUM_IN-1:0] r);
        for (int i = 0; i < NUM_IN; i++)
            if (r[(p + i) % NUM_IN]) return (p + i) % NUM_IN;
        return -1;
    endfunction

    function automatic logic [NUM_IN-1:0] m_grant(input mstate_t s, input logic [NUM_IN-1:0] r);
        logic [NUM_IN-1:0] g;
        g = '0;
        if (s.own && r[s.owner] && s.cred > 0) g[s.owner] = 1'b1;
        return g;
    endfunction

    function automatic mstate_t m_reset();
        mstate_t s;
        s.own = 0; s.owner = 0; s.rr = 0; s.cred = MAX_CREDIT; s.err = 0;
        return s;
    endfunction

    function automatic mstate_t m_step(input mstate_t s, input bit lock,
                                       input logic [NUM_IN-1:0] r, input logic [NUM_IN-1:0] t,
                                       input bit ci);
        mstate_t n;
        bit      g;
        bit      rel;
        n = s;
        g = (m_grant(s, r) != '0);
        if (!s.own) begin
            if (r != '0) begin
                n.own   = 1;
                n.owner = m_pick(s.rr, r);
            end
        end else begin
            rel = !r[s.owner] || (lock && g && t[s.owner]);
            if (rel) begin
                n.rr = (s.owner + 1) % NUM_IN;
                if (r != '0) n.owner = m_pick(n.rr, r);
                else         n.own = 0;
            end
        end
        n.cred = s.cred - (g ? 1 : 0) + (ci ? 1 : 0);
        if (n.cred > MAX_CREDIT) begin
            n.cred = MAX_CREDIT;
            n.err  = 1;
        end
        return n;
    endfunction

    task automatic cmp(input int d, input logic [NUM_IN-1:0] g, input logic ov,
                       input logic [CREDIT_W-1:0] cc, input logic ce);
        string tag;
        tag = (d == 0) ? "lock0" : "lock1";
        if (!reset) m[d] = m_reset();
        check({tag, " grant"},       32'(g),  32'(m_grant(m[d], req_v)));
        check({tag, " owner_valid"}, 32'(ov), 32'(m[d].own));
        check({tag, " credit_cnt"},  32'(cc), 32'(m[d].cred));
        check({tag, " credit_err"},  32'(ce), 32'(m[d].err));
        if (reset) m[d] = m_step(m[d], d == 1, req_v, tail_v, ci_v);
    endtask

    always @(negedge clk) begin
        cycle++;
        cmp(0, if0.grant, if0.owner_valid, if0.credit_cnt, if0.credit_err);
        cmp(1, if1.grant, if1.owner_valid, if1.credit_cnt, if1.credit_err);
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic at_sample();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset  = 1'b0;
        req_v  = '0;
        tail_v = '0;
        ci_v   = 1'b0;
        cyc();
        cyc();
        reset = 1'b1;
    endtask

    initial begin
        logic [NUM_IN-1:0] exp_g [6];
        logic              t0    [6];
        n_tests = 0;
        n_fail  = 0;
        cycle   = 0;
        reset   = 1'b0;
        req_v   = '0;
        tail_v  = '0;
        ci_v    = 1'b0;

        // Single requester drains all credits, then stalls.
        do_reset();
        req_v = 5'b00001;
        at_sample();
        check("t1 first cycle grant", 32'(if1.grant), 32'h0);
        check("t1 first cycle owner_valid", 32'(if1.owner_valid), 32'h0);
        cyc();
        for (int k = 0; k < 4; k++) begin
            at_sample();
            check("t1 drain grant", 32'(if1.grant), 32'h1);
            check("t1 drain owner_valid", 32'(if1.owner_valid), 32'h1);
            check("t1 drain credit", 32'(if1.credit_cnt), 32'(4 - k));
            cyc();
        end
        at_sample();
        check("t1 stall grant", 32'(if1.grant), 32'h0);
        check("t1 stall credit", 32'(if1.credit_cnt), 32'h0);
        cyc();

        // One credit returned while stalled, then grant and credit together at 2.
        ci_v = 1'b1;
        at_sample();
        cyc();
        ci_v = 1'b0;
        at_sample();
        check("t2 refill credit", 32'(if1.credit_cnt), 32'h1);
        check("t2 refill grant", 32'(if1.grant), 32'h1);
        cyc();
        at_sample();
        check("t2 empty again", 32'(if1.credit_cnt), 32'h0);
        cyc();
        req_v = '0;
        ci_v  = 1'b1;
        at_sample();
        cyc();
        at_sample();
        cyc();
        req_v = 5'b00001;
        ci_v  = 1'b0;
        at_sample();
        check("t2 idle after abort", 32'(if1.owner_valid), 32'h0);
        check("t2 credit at two", 32'(if1.credit_cnt), 32'h2);
        cyc();
        ci_v = 1'b1;
        at_sample();
        check("t2 grant with credit_in", 32'(if1.grant), 32'h1);
        cyc();
        ci_v = 1'b0;
        at_sample();
        check("t2 credit unchanged", 32'(if1.credit_cnt), 32'h2);
        cyc();

        // Packet lock and round-robin rotation with req=10101.
        do_reset();
        req_v  = 5'b10101;
        tail_v = 5'b10100;
        exp_g  = '{5'b00001, 5'b00001, 5'b00001, 5'b00100, 5'b10000, 5'b00001};
        t0     = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        at_sample();
        check("t3 idle grant", 32'(if1.grant), 32'h0);
        cyc();
        ci_v = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tail_v[0] = t0[k];
            at_sample();
            check("t3 rr grant", 32'(if1.grant), 32'(exp_g[k]));
            cyc();
        end
        at_sample();
        check("t3 credit steady", 32'(if1.credit_cnt), 32'h4);
        req_v  = '0;
        tail_v = '0;
        ci_v   = 1'b0;
        cyc();

        // Non-locking owner drops req: ownership moves without an idle cycle.
        do_reset();
        req_v = 5'b00011;
        at_sample();
        cyc();
        at_sample();
        check("t4 owner0 grant", 32'(if0.grant), 32'h1);
        cyc();
        req_v = 5'b00010;
        at_sample();
        check("t4 drop grant", 32'(if0.grant), 32'h0);
        check("t4 drop owner_valid", 32'(if0.owner_valid), 32'h1);
        cyc();
        req_v = 5'b00011;
        at_sample();
        check("t4 switched grant", 32'(if0.grant), 32'h2);
        check("t4 switched owner_valid", 32'(if0.owner_valid), 32'h1);
        cyc();

        // Credit overflow sets the sticky error.
        do_reset();
        ci_v = 1'b1;
        at_sample();
        cyc();
        ci_v  = 1'b0;
        req_v = 5'b00001;
        at_sample();
        check("t5 saturated credit", 32'(if1.credit_cnt), 32'h4);
        check("t5 err set", 32'(if1.credit_err), 32'h1);
        cyc();
        for (int k = 0; k < 3; k++) begin
            at_sample();
            check("t5 err sticky", 32'(if1.credit_err), 32'h1);
            cyc();
        end
        do_reset();
        at_sample();
        check("t5 err cleared", 32'(if1.credit_err), 32'h0);
        cyc();

        // Asynchronous reset mid-packet.
        do_reset();
        req_v = 5'b01000;
        at_sample();
        cyc();
        for (int k = 0; k < 3; k++) begin
            at_sample();
            cyc();
        end
        at_sample();
        check("t6 owner3 grant", 32'(if1.grant), 32'h8);
        check("t6 credit one", 32'(if1.credit_cnt), 32'h1);
        #1;
        reset = 1'b0;
        #1;
        check("t6 async grant", 32'(if1.grant), 32'h0);
        check("t6 async owner_valid", 32'(if1.owner_valid), 32'h0);
        check("t6 async credit", 32'(if1.credit_cnt), 32'h4);
        cyc();
        at_sample();
        cyc();
        reset = 1'b1;
        at_sample();
        check("t6 post reset idle", 32'(if1.grant), 32'h0);
        cyc();
        at_sample();
        check("t6 post reset grant", 32'(if1.grant), 32'h8);
        cyc();

        // Randomised traffic against the model.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 3) == 0) req_v = NUM_IN'($urandom);
            tail_v = NUM_IN'($urandom & $urandom);
            ci_v   = ($urandom_range(0, 1) == 0);
            reset  = ($urandom_range(0, 199) != 0);
            cyc();
        end
        reset = 1'b1;
        at_sample();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/arbiter_out_rr.md
Name: arbiter_out_rr

Overview:
- Parametrised output-port arbiter for the credit-based router; one instance per output port.
- Selects one of NUM_IN LBDR request lines and issues a one-hot grant.
- Keeps its own downstream credit counter instead of taking a credit-level input.
- Locks ownership for a whole packet (head to tail) and rotates priority round-robin on release, removing the fixed-order bias of the earlier output arbiter.

Parameters:
- NUM_IN, 5, number of requesting input ports (N,E,W,S,L order at index 0..4 in the router).
- MAX_CREDIT, 4, downstream FIFO depth; credit counter reset value and ceiling.
- CREDIT_W, 3, credit counter width; must satisfy 2^CREDIT_W > MAX_CREDIT.
- LOCK_PKT, 1, 1 = hold owner until its tail flit is granted; 0 = hold owner only while its req stays high.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  asynchronous active-low reset.
- req  input  NUM_IN  request from each input's LBDR for this output.
- tail  input  NUM_IN  current flit at input i is a tail flit; qualified by req[i].
- credit_in  input  1  one-cycle pulse = one downstream slot freed.
- grant  output  NUM_IN  one-hot grant to input i (combinational from registered state).
- owner_valid  output  1  registered; an input currently owns the output.
- credit_cnt  output  CREDIT_W  registered available downstream credits.
- credit_err  output  1  sticky: credit_in received while credit_cnt == MAX_CREDIT.

Behaviour:
- Reset (reset=0, async) sets state IDLE, owner index 0, rr pointer 0, credit_cnt=MAX_CREDIT and credit_err=0. With state IDLE, grant=0 and owner_valid=0.
- States: IDLE, OWN(k) for k in 0..NUM_IN-1. Encoding is internal, with owner index and a valid bit.
- Arbitration function pick(p): the first i with req[i]=1 scanning p, p+1, ..., wrapping modulo NUM_IN.
- IDLE: if any req, next state is OWN(pick(rr)); otherwise stay IDLE. No grant in IDLE, so the first grant comes 1 cycle after the request is seen.
- OWN(k) grant rule: grant[k]=1 iff req[k]=1 and credit_cnt != 0. All other grant bits are 0. At most one grant bit is ever high.
- OWN(k) release, LOCK_PKT=1: release when grant[k] and tail[k] are both 1 in the same cycle.
- OWN(k) release, LOCK_PKT=0: release when req[k]=0.
- Also release when req[k]=0 and LOCK_PKT=1. This is a protocol abort; the owner is dropped with no error flag.
- On release, rr becomes (k+1) mod NUM_IN. In the same cycle the next state is OWN(pick((k+1) mod NUM_IN)) if any req is high, else IDLE. There is no bubble cycle between packets.
- Without release, the state stays OWN(k), including while stalled at credit_cnt=0.
- Credit counter update: credit_cnt_next = credit_cnt − (|grant) + credit_in.
  - Grant and credit_in in the same cycle leave the count unchanged.
  - No grant is possible at 0, so the count never underflows.
  - credit_in at MAX_CREDIT with no grant: the count saturates at MAX_CREDIT and credit_err is set to 1. Only reset clears credit_err.
- Reset asserted mid-packet immediately drops grant and returns to IDLE with a full credit count. No flit state is retained.
- Requests from non-owners are ignored until release. Non-owner tail bits are ignored.

Test Plan:
- Reset, then req=5'b00001 with tail=0 → grant=0 in cycle 0; grant=5'b00001 and owner_valid=1 from cycle 1; credit_cnt decrements 4→3→2→1→0, then grant=0 while req stays high.
- Owner 0 stalled at credit_cnt=0, then one credit_in pulse → credit_cnt=1, one grant cycle, back to 0. Grant plus credit_in in the same cycle at count 2 → count stays 2.
- req=5'b10101 and LOCK_PKT=1; input 0 sends a 3-flit packet with tail on flit 3 → owner 0 for exactly 3 grants. The next cycle grants input 2 (rr=1 skips idle 1), then input 4, then wraps to 0.
- LOCK_PKT=0, req=5'b00011, owner 0 drops req for one cycle → owner switches to input 1 in the same cycle with no IDLE state; the grant moves to 5'b00010 on the following cycle.
- Credit counter at MAX_CREDIT=4, credit_in pulse with no grant → credit_cnt stays 4 and credit_err=1 and remains 1 until reset.
- Assert reset mid-packet (owner 3, credit_cnt=1) → grant=0, owner_valid=0 and credit_cnt=4 asynchronously. After deassertion, req=5'b01000 is granted again after 1 cycle.
